// File: rtl/step_ctrl.sv
// Turns debounced press pulses into single-step or run/halt toggles using an m_f-tick double-press window.
// Outputs are registered, one clk after the deciding press or tick. There is no backpressure; presses in HOLD are dropped.
module step_ctrl #(
  parameter int DBL_WINDOW = 250,
  parameter int HOLDOFF    = 100,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m_f,
  input  logic       press,
  output logic       step,
  output logic       run,
  output logic       run_tgl,
  output logic       busy,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT2 = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DBL_WINDOW - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      step     <= 1'b0;
      run      <= 1'b0;
      run_tgl  <= 1'b0;
      busy     <= 1'b0;
      step_cnt <= '0;
    end else begin
      step    <= 1'b0;
      run_tgl <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press) begin
            state <= WAIT2;
            busy  <= 1'b1;
          end
        end
        WAIT2: begin
          // A press on the timeout tick still counts as the second press.
          if (press) begin
            run     <= ~run;
            run_tgl <= 1'b1;
            cnt     <= '0;
            state   <= HOLD;
          end else if (m_f) begin
            if (cnt == WIN_LAST) begin
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (run) begin
                run     <= 1'b0;
                run_tgl <= 1'b1;
              end else begin
                step     <= 1'b1;
                step_cnt <= step_cnt + 8'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (m_f) begin
            if (cnt == HOLD_LAST) begin
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Randomized and directed bench for step_ctrl with a tick-counting reference model and an event scoreboard.
module tb_step_ctrl;
  localparam int DBL_WINDOW = 4;
  localparam int HOLDOFF    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_f = 1'b0;
  logic       press = 1'b0;
  logic       step, run, run_tgl, busy;
  logic [7:0] step_cnt;

  step_ctrl #(.DBL_WINDOW(DBL_WINDOW), .HOLDOFF(HOLDOFF), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .m_f(m_f), .press(press),
    .step(step), .run(run), .run_tgl(run_tgl), .busy(busy), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_step;
    bit run;
    int cnt;
    int cyc;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 0;
  int  div = 0;

  // Reference model: a press opens a window of DBL_WINDOW ticks; a second press
  // inside it toggles run and starts a HOLDOFF-tick dead period.
  int  mode = 0;       // 0 idle, 1 waiting for second press, 2 dead time
  int  ticks_seen = 0;
  bit  m_run = 0;
  int  m_cnt = 0;
  bit  m_busy = 0;

  always @(posedge clk) begin
    ev_t e;
    cyc++;
    if (!rst) begin
      mode = 0; ticks_seen = 0; m_run = 0; m_cnt = 0;
    end else if (mode == 0) begin
      if (press) begin mode = 1; ticks_seen = 0; end
    end else if (mode == 1) begin
      if (press) begin
        m_run = !m_run;
        e.is_step = 0; e.run = m_run; e.cnt = m_cnt; e.cyc = cyc;
        expq.push_back(e);
        mode = 2; ticks_seen = 0;
      end else if (m_f) begin
        ticks_seen++;
        if (ticks_seen == DBL_WINDOW) begin
          mode = 0;
          if (!m_run) begin
            m_cnt = (m_cnt + 1) % 256;
            e.is_step = 1; e.run = 0; e.cnt = m_cnt; e.cyc = cyc;
          end else begin
            m_run = 0;
            e.is_step = 0; e.run = 0; e.cnt = m_cnt; e.cyc = cyc;
          end
          expq.push_back(e);
        end
      end
    end else begin
      if (m_f) begin
        ticks_seen++;
        if (ticks_seen == HOLDOFF) mode = 0;
      end
    end
    m_busy = (mode != 0);
  end

  // Monitor: levels every cycle, pulses against the scoreboard queue.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      checks++;
      if (busy !== m_busy || run !== m_run || step_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL level cyc=%0d busy=%b exp %b run=%b exp %b step_cnt=%0d exp %0d",
                 cyc, busy, m_busy, run, m_run, step_cnt, m_cnt);
      end
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        checks++; errors++;
        $display("FAIL missing_event cyc=%0d got nothing, exp %s at cyc %0d",
                 cyc, e.is_step ? "step" : "run_tgl", e.cyc);
      end
      if (step === 1'b1 || run_tgl === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d step=%b run_tgl=%b exp none", cyc, step, run_tgl);
        end else begin
          e = expq.pop_front();
          if (e.cyc != cyc || step !== e.is_step || run_tgl !== !e.is_step ||
              run !== e.run || step_cnt !== 8'(e.cnt)) begin
            errors++;
            $display("FAIL event cyc=%0d step=%b run_tgl=%b run=%b cnt=%0d exp cyc=%0d step=%b run=%b cnt=%0d",
                     cyc, step, run_tgl, run, step_cnt, e.cyc, e.is_step, e.run, e.cnt);
          end
        end
      end
    end
  end

  task automatic drive(input bit p);
    press = p;
    m_f = (div == 9);
    div = (div + 1) % 10;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0);
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp_v);
    end
  endtask

  initial begin
    @(negedge clk);
    // 1. Reset while pressing and ticking
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i % 2 == 0);
      mon_en = 1;
    end
    check_val("rst_step", {7'd0, step}, 8'd0);
    check_val("rst_run", {7'd0, run}, 8'd0);
    check_val("rst_tgl", {7'd0, run_tgl}, 8'd0);
    check_val("rst_busy", {7'd0, busy}, 8'd0);
    check_val("rst_cnt", step_cnt, 8'd0);
    rst = 1;
    idle(3);
    check_val("post_rst_busy", {7'd0, busy}, 8'd0);
    check_val("post_rst_cnt", step_cnt, 8'd0);

    // 2. Single press, run=0
    drive(1); idle(60);
    check_val("single_cnt", step_cnt, 8'd1);
    check_val("single_run", {7'd0, run}, 8'd0);

    // 3. Double press, third press during HOLD
    drive(1); idle(14); drive(1); idle(3); drive(1); idle(50);
    check_val("double_run", {7'd0, run}, 8'd1);

    // 4. Single press while running halts
    drive(1); idle(60);
    check_val("halt_run", {7'd0, run}, 8'd0);
    check_val("halt_cnt", step_cnt, 8'd1);

    // 5a. Second press on the window-closing tick
    begin
      int t;
      drive(1);
      t = 0;
      while (t < DBL_WINDOW - 1) begin
        if (div == 9) t++;
        drive(0);
      end
      while (div != 9) drive(0);
      drive(1);
      idle(50);
    end
    check_val("coinc_run", {7'd0, run}, 8'd1);
    check_val("coinc_cnt", step_cnt, 8'd1);

    // 5b. Reset in the middle of the window
    drive(1); idle(15);
    rst = 0; idle(2); rst = 1;
    idle(60);
    check_val("midrst_cnt", step_cnt, 8'd0);

    // 6. 256 single presses wrap the counter
    for (int k = 0; k < 256; k++) begin
      drive(1);
      idle(42 + $urandom_range(0, 5));
    end
    check_val("wrap_cnt", step_cnt, 8'd0);

    // Press landing on the HOLD exit tick is lost
    begin
      int t;
      drive(1); idle(3); drive(1);
      t = 0;
      while (t < HOLDOFF - 1) begin
        if (div == 9) t++;
        drive(0);
      end
      while (div != 9) drive(0);
      drive(1);
      idle(60);
    end
    check_val("hold_exit_busy", {7'd0, busy}, 8'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) rst = 0;
      else rst = 1;
      drive($urandom_range(0, 14) == 0);
    end
    rst = 1;
    idle(80);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
